// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared state encoding and default parameters for run_controller
package run_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, REQ, RUN, DUMP, FINISH} state_t;
    localparam int DEF_CYCLE_WIDTH    = 32;
    localparam int DEF_TIMEOUT_CYCLES = 1000000;
    localparam int DEF_ADDR_WIDTH     = 8;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter with clear that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clk)
        if (reset || clear) count <= '0;
        else if (inc && count != '1) count <= count + WIDTH'(1);
endmodule

// File: rtl/run_controller.sv
// run_controller: pulses the processor, times the run with a timeout, then streams
// a window of data memory back to the host through a valid/ready port
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int CYCLE_WIDTH    = DEF_CYCLE_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  dump_base,
    input  logic [ADDR_WIDTH:0]    dump_len,
    output logic                   req,
    input  logic                   done,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [7:0]             mem_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_data,
    output logic [ADDR_WIDTH-1:0]  out_addr,
    output logic                   busy,
    output logic                   finished,
    output logic                   timeout,
    output logic [CYCLE_WIDTH-1:0] cycle_count
);
    localparam logic [CYCLE_WIDTH-1:0] LIMIT = CYCLE_WIDTH'(TIMEOUT_CYCLES - 1);
    state_t state, state_nxt;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH:0] len, idx;
    logic cnt_clr, cnt_inc, tmo_set;
    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        finished  = 1'b0;
        out_valid = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        tmo_set   = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_nxt = REQ;
                cnt_clr   = 1'b1;
            end
            REQ: begin
                req       = 1'b1;
                state_nxt = RUN;
            end
            RUN: if (done) state_nxt = len != '0 ? DUMP : FINISH;
            else begin
                cnt_inc = 1'b1;
                if (cycle_count == LIMIT) begin
                    tmo_set   = 1'b1;
                    state_nxt = FINISH;
                end
            end
            DUMP: begin
                out_valid = 1'b1;
                if (out_ready && idx == len - (ADDR_WIDTH + 1)'(1)) state_nxt = FINISH;
            end
            FINISH: begin
                finished  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
    assign busy     = state != IDLE;
    assign mem_addr = state == DUMP ? base + idx[ADDR_WIDTH-1:0] : '0;
    assign out_addr = mem_addr;
    assign out_data = state == DUMP ? mem_data : '0;
    always_ff @(posedge clk)
        if (reset) begin
            state   <= IDLE;
            base    <= '0;
            len     <= '0;
            idx     <= '0;
            timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            if (cnt_clr) begin
                base    <= dump_base;
                len     <= dump_len;
                idx     <= '0;
                timeout <= 1'b0;
            end
            if (tmo_set) timeout <= 1'b1;
            if (out_valid && out_ready) idx <= idx + (ADDR_WIDTH + 1)'(1);
        end
    sat_counter #(.WIDTH(CYCLE_WIDTH)) u_cnt (
        .clk  (clk),
        .reset(reset),
        .clear(cnt_clr),
        .inc  (cnt_inc),
        .count(cycle_count)
    );
endmodule

// File: tb/tb_run_controller.sv
// tb_run_controller: randomized runs against a queue-based reference of the expected
// req / transfer / finish sequence, checked by an independent monitor
module tb_run_controller;
    localparam int T = 50;
    logic clk = 1'b0;
    logic reset, start, done, out_ready;
    logic req, out_valid, busy, finished, timeout;
    logic [7:0] dump_base, mem_addr, mem_data, out_data, out_addr;
    logic [8:0] dump_len;
    logic [31:0] cycle_count;
    logic [7:0] mem [256];
    int n_cmp = 0, n_bad = 0;
    typedef struct {int kind; int addr; int data; int tmo; int cnt; bit dumped;} exp_t;
    exp_t sb[$];
    assign mem_data = mem[mem_addr];
    always #5 clk = ~clk;
    run_controller #(.CYCLE_WIDTH(32), .TIMEOUT_CYCLES(T), .ADDR_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .dump_base(dump_base), .dump_len(dump_len),
        .req(req), .done(done), .mem_addr(mem_addr), .mem_data(mem_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
        .busy(busy), .finished(finished), .timeout(timeout), .cycle_count(cycle_count)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic take(input int kind, output exp_t e, output bit ok);
        chk("event_kind", sb.size() == 0 ? -1 : sb[0].kind, kind);
        ok = sb.size() != 0 && sb[0].kind == kind;
        if (ok) e = sb.pop_front();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req"}, req, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_finished"}, finished, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_cycle_count"}, cycle_count, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_out_data"}, out_data, 0);
    endtask

    // monitor: every DUT-presented event is matched against the head of the queue
    int cyc = 0, last_xfer = -10;
    bit prev_stall = 1'b0;
    logic [7:0] prev_addr;
    always @(negedge clk) begin
        exp_t e;
        bit ok;
        cyc++;
        if (reset) prev_stall = 1'b0;
        else begin
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_addr", out_addr, prev_addr);
            end
            if (!out_valid) chk("mem_addr_idle", mem_addr, 0);
            if (req) take(0, e, ok);
            if (out_valid && out_ready) begin
                take(1, e, ok);
                if (ok) begin
                    chk("out_addr", out_addr, e.addr);
                    chk("mem_addr", mem_addr, e.addr);
                    chk("out_data", out_data, e.data);
                end
                last_xfer = cyc;
            end
            if (finished) begin
                take(2, e, ok);
                if (ok) begin
                    chk("fin_timeout", timeout, e.tmo);
                    chk("fin_cycle_count", cycle_count, e.cnt);
                    if (e.dumped) chk("fin_after_last", cyc - last_xfer, 1);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_addr  = out_addr;
        end
    end

    // d = RUN cycles with done low before done rises; rmode 0:ready=1 1:toggle 2:random
    task automatic run_once(input int base, input int len, input int d, input bit stale,
                            input int rmode, input bit noise, input int abort);
        exp_t e;
        int k;
        bit tmo;
        tmo = d >= T;
        e = '{0, 0, 0, 0, 0, 1'b0};
        sb.push_back(e);
        if (!tmo)
            for (int i = 0; i < len; i++) begin
                e = '{1, (base + i) % 256, int'(mem[(base + i) % 256]), 0, 0, 1'b0};
                sb.push_back(e);
            end
        e = '{2, 0, 0, int'(tmo), tmo ? T : d, !tmo && len > 0};
        sb.push_back(e);
        dump_base = 8'(base);
        dump_len  = 9'(len);
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("req_latency", req, 1);
        chk("busy_run", busy, 1);
        k = 0;
        forever begin
            done = k == 0 ? stale : k > d;
            out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? k % 2 == 0 : 1'($urandom_range(0, 1));
            if (noise) begin
                start     = 1'($urandom_range(0, 1));
                dump_base = 8'($urandom);
                dump_len  = 9'($urandom_range(0, 256));
            end
            if (abort > 0 && k == abort) begin
                reset = 1'b1;
                @(posedge clk); #1;
                chk_zero("abort");
                reset = 1'b0;
                sb.delete();
                start = 1'b0;
                return;
            end
            @(posedge clk); #1;
            k++;
            if (!busy) break;
            if (k > 3000) begin
                n_cmp++;
                n_bad++;
                $display("FAIL run_budget: got busy after %0d cycles, want idle", k);
                break;
            end
        end
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("hold_cycle_count", cycle_count, tmo ? T : d);
        chk("hold_timeout", timeout, tmo);
    endtask

    initial begin
        foreach (mem[i]) mem[i] = 8'($urandom);
        reset = 1'b1; start = 1'b1; done = 1'b0; out_ready = 1'b0;
        dump_base = 8'h33; dump_len = 9'd5;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        chk("busy_after_reset", busy, 0);
        run_once(8'h10, 3, 20, 1'b0, 0, 1'b0, 0);
        run_once(8'h20, 4, 1000, 1'b0, 0, 1'b0, 0);
        run_once(8'hFE, 4, 7, 1'b0, 1, 1'b0, 0);
        run_once(8'h40, 2, 0, 1'b1, 0, 1'b0, 0);
        run_once(8'h00, 200, 5, 1'b0, 0, 1'b0, 30);
        run_once(8'h55, 0, 6, 1'b0, 0, 1'b0, 0);
        run_once(8'h80, 5, 10, 1'b0, 2, 1'b1, 0);
        run_once(8'h37, 256, 3, 1'b0, 2, 1'b0, 0);
        run_once(8'h01, 2, T - 1, 1'b0, 0, 1'b0, 0);
        run_once(8'h02, 2, T, 1'b0, 0, 1'b0, 0);
        for (int r = 0; r < 12; r++) begin
            int pick;
            pick = $urandom_range(0, 2);
            run_once($urandom_range(0, 255),
                     pick == 0 ? 0 : pick == 1 ? $urandom_range(1, 8) : $urandom_range(1, 40),
                     $urandom_range(0, 60), 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                     1'($urandom_range(0, 1)), 0);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
